// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the fetch PC, issues one 32-bit read at a time
// to the memory controller and pushes each returned word into the instruction queue.
module inst_fetch #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [INST_WIDTH-1:0] NOP_INST   = INST_WIDTH'(32'h00000013)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  instqueue_if_full_in,
  output logic                  if_instqueue_en_out,
  output logic [INST_WIDTH-1:0] if_instqueue_inst_out,
  output logic [ADDR_WIDTH-1:0] if_instqueue_pc_out,
  output logic                  if_mc_en_out,
  output logic [ADDR_WIDTH-1:0] if_mc_addr_out,
  input  logic                  mc_if_rdy_in,
  input  logic [INST_WIDTH-1:0] mc_if_inst_in,
  input  logic                  rob_if_rst_in,
  input  logic [ADDR_WIDTH-1:0] rob_if_pc_in,
  input  logic                  bp_if_rst_in,
  input  logic [ADDR_WIDTH-1:0] bp_if_pc_in
);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] pc, pc_nx;
  logic                  mc_en_nx;
  logic [ADDR_WIDTH-1:0] mc_addr_nx;
  logic                  push_nx;
  logic [INST_WIDTH-1:0] inst_nx;
  logic [ADDR_WIDTH-1:0] push_pc_nx;

  logic                  redir;
  logic [ADDR_WIDTH-1:0] target;

  assign redir  = rob_if_rst_in | bp_if_rst_in;
  assign target = rob_if_rst_in ? rob_if_pc_in : bp_if_pc_in;

  always_comb begin
    state_nx   = state;
    pc_nx      = pc;
    mc_en_nx   = if_mc_en_out;
    mc_addr_nx = if_mc_addr_out;
    push_nx    = 1'b0;
    inst_nx    = if_instqueue_inst_out;
    push_pc_nx = if_instqueue_pc_out;
    case (state)
      IDLE: begin
        if (redir) begin
          pc_nx = target;
        end else if (!instqueue_if_full_in) begin
          mc_en_nx   = 1'b1;
          mc_addr_nx = pc;
          state_nx   = WAIT;
        end
      end
      WAIT: begin
        if (mc_if_rdy_in) begin
          mc_en_nx = 1'b0;
          state_nx = IDLE;
          if (redir) begin
            pc_nx = target;
          end else begin
            push_nx    = 1'b1;
            inst_nx    = mc_if_inst_in;
            push_pc_nx = pc;
            pc_nx      = pc + ADDR_WIDTH'(4);
          end
        end else if (redir) begin
          // Keep the request up: the controller must finish this read before we move on.
          pc_nx    = target;
          state_nx = DROP;
        end
      end
      DROP: begin
        if (redir) pc_nx = target;
        if (mc_if_rdy_in) begin
          mc_en_nx = 1'b0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state                 <= IDLE;
      pc                    <= RESET_PC;
      if_mc_en_out          <= 1'b0;
      if_mc_addr_out        <= '0;
      if_instqueue_en_out   <= 1'b0;
      if_instqueue_inst_out <= NOP_INST;
      if_instqueue_pc_out   <= '0;
    end else if (rdy_in) begin
      state                 <= state_nx;
      pc                    <= pc_nx;
      if_mc_en_out          <= mc_en_nx;
      if_mc_addr_out        <= mc_addr_nx;
      if_instqueue_en_out   <= push_nx;
      if_instqueue_inst_out <= inst_nx;
      if_instqueue_pc_out   <= push_pc_nx;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a latency-programmable memory model plus a
// negedge monitor logging requests and pushes; one task per scenario.
module tb_inst_fetch;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        full;
  logic        push;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        mc_en;
  logic [31:0] mc_addr;
  logic        mc_rdy;
  logic [31:0] mc_inst;
  logic        rob_rst, bp_rst;
  logic [31:0] rob_pc, bp_pc;

  inst_fetch dut (
    .clk_in                (clk_in),
    .rst_in                (rst_in),
    .rdy_in                (rdy_in),
    .instqueue_if_full_in  (full),
    .if_instqueue_en_out   (push),
    .if_instqueue_inst_out (inst_out),
    .if_instqueue_pc_out   (pc_out),
    .if_mc_en_out          (mc_en),
    .if_mc_addr_out        (mc_addr),
    .mc_if_rdy_in          (mc_rdy),
    .mc_if_inst_in         (mc_inst),
    .rob_if_rst_in         (rob_rst),
    .rob_if_pc_in          (rob_pc),
    .bp_if_rst_in          (bp_rst),
    .bp_if_pc_in           (bp_pc)
  );

  always #5 clk_in = ~clk_in;

  // Memory model: answers a held request after lat cycles with {16'hC0DE, addr[15:0]}.
  int          lat = 1;
  logic        mem_auto = 1'b1;
  logic        auto_rdy, man_rdy = 1'b0;
  logic [31:0] auto_inst, man_inst = '0;
  int          mcnt;

  assign mc_rdy  = mem_auto ? auto_rdy  : man_rdy;
  assign mc_inst = mem_auto ? auto_inst : man_inst;

  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      auto_rdy  <= 1'b0;
      auto_inst <= '0;
      mcnt      <= 0;
    end else if (auto_rdy) begin
      auto_rdy <= 1'b0;
      mcnt     <= 0;
    end else if (mc_en) begin
      if (mcnt + 1 >= lat) begin
        auto_rdy  <= 1'b1;
        auto_inst <= {16'hC0DE, mc_addr[15:0]};
      end else begin
        mcnt <= mcnt + 1;
      end
    end
  end

  // Monitor
  logic [31:0] push_inst_log[64];
  logic [31:0] push_pc_log[64];
  int          push_cyc_log[64];
  logic [31:0] req_log[64];
  int          push_cnt = 0, req_cnt = 0, cyc_cnt = 0, wide_err = 0;
  logic        push_d = 1'b0, mc_en_d = 1'b0;

  always @(negedge clk_in) begin
    cyc_cnt++;
    if (rst_in === 1'b1) begin
      if (push) begin
        if (push_d) wide_err++;
        if (push_cnt < 64) begin
          push_inst_log[push_cnt] = inst_out;
          push_pc_log[push_cnt]   = pc_out;
          push_cyc_log[push_cnt]  = cyc_cnt;
        end
        push_cnt++;
      end
      if (mc_en && !mc_en_d && req_cnt < 64) begin
        req_log[req_cnt] = mc_addr;
        req_cnt++;
      end
    end
    push_d  = push && (rst_in === 1'b1);
    mc_en_d = mc_en;
  end

  int n_chk = 0, n_pass = 0;

  task automatic cyc();
    @(negedge clk_in);
    #1;
  endtask

  task automatic wait_push(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      cyc();
      if (push_cnt >= target) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b1; rdy_in = 1'b1; full = 1'b0;
    rob_rst = 1'b0; bp_rst = 1'b0; rob_pc = '0; bp_pc = '0;
    #2 rst_in = 1'b0;
    cyc(); cyc();
    n_chk++; if (mc_en !== 1'b0) $display("FAIL reset_mc_en: got %0h want 0", mc_en); else n_pass++;
    n_chk++; if (mc_addr !== 32'h0) $display("FAIL reset_mc_addr: got %0h want 0", mc_addr); else n_pass++;
    n_chk++; if (push !== 1'b0) $display("FAIL reset_push: got %0h want 0", push); else n_pass++;
    n_chk++; if (inst_out !== 32'h00000013) $display("FAIL reset_inst: got %0h want 13", inst_out); else n_pass++;
    n_chk++; if (pc_out !== 32'h0) $display("FAIL reset_pc_out: got %0h want 0", pc_out); else n_pass++;
  endtask

  task automatic test_sequential();
    int  bp = push_cnt, br = req_cnt;
    bit  ok;
    lat = 1;
    rst_in = 1'b1;
    wait_push(bp + 3, 40, ok);
    full = 1'b1;
    n_chk++; if (!ok) $display("FAIL seq_timeout: got %0d pushes want 3", push_cnt - bp); else n_pass++;
    n_chk++; if (req_cnt - br !== 3) $display("FAIL seq_req_count: got %0d want 3", req_cnt - br); else n_pass++;
    n_chk++; if (req_log[br] !== 32'h0 || req_log[br+1] !== 32'h4 || req_log[br+2] !== 32'h8)
      $display("FAIL seq_req_addr: got %0h %0h %0h want 0 4 8", req_log[br], req_log[br+1], req_log[br+2]); else n_pass++;
    n_chk++; if (push_pc_log[bp] !== 32'h0 || push_pc_log[bp+1] !== 32'h4 || push_pc_log[bp+2] !== 32'h8)
      $display("FAIL seq_push_pc: got %0h %0h %0h want 0 4 8", push_pc_log[bp], push_pc_log[bp+1], push_pc_log[bp+2]); else n_pass++;
    n_chk++; if (push_inst_log[bp] !== 32'hC0DE0000 || push_inst_log[bp+1] !== 32'hC0DE0004 || push_inst_log[bp+2] !== 32'hC0DE0008)
      $display("FAIL seq_push_inst: got %0h %0h %0h want c0de0000 c0de0004 c0de0008", push_inst_log[bp], push_inst_log[bp+1], push_inst_log[bp+2]); else n_pass++;
    n_chk++; if (push_cyc_log[bp+1] - push_cyc_log[bp] !== 3 || push_cyc_log[bp+2] - push_cyc_log[bp+1] !== 3)
      $display("FAIL seq_spacing: got %0d %0d want 3 3", push_cyc_log[bp+1] - push_cyc_log[bp], push_cyc_log[bp+2] - push_cyc_log[bp+1]); else n_pass++;
    n_chk++; if (wide_err !== 0) $display("FAIL seq_pulse_width: got %0d wide pulses want 0", wide_err); else n_pass++;
  endtask

  task automatic test_full();
    int br = req_cnt;
    repeat (5) cyc();
    n_chk++; if (req_cnt !== br || mc_en !== 1'b0) $display("FAIL full_hold: got req %0d en %0h want 0 0", req_cnt - br, mc_en); else n_pass++;
    lat = 4;
    full = 1'b0;
    cyc();
    n_chk++; if (mc_en !== 1'b1 || mc_addr !== 32'hC) $display("FAIL full_release: got en %0h addr %0h want 1 c", mc_en, mc_addr); else n_pass++;
  endtask

  task automatic test_drop();
    int bp = push_cnt, br = req_cnt;
    bit ok;
    bp_rst = 1'b1; bp_pc = 32'h100;
    cyc();
    bp_rst = 1'b0; bp_pc = '0;
    n_chk++; if (mc_en !== 1'b1 || mc_addr !== 32'hC) $display("FAIL drop_req_held: got en %0h addr %0h want 1 c", mc_en, mc_addr); else n_pass++;
    wait_push(bp + 1, 40, ok);
    full = 1'b1;
    n_chk++; if (!ok) $display("FAIL drop_timeout: got %0d pushes want 1", push_cnt - bp); else n_pass++;
    n_chk++; if (push_pc_log[bp] !== 32'h100 || push_inst_log[bp] !== 32'hC0DE0100)
      $display("FAIL drop_push: got pc %0h inst %0h want 100 c0de0100", push_pc_log[bp], push_inst_log[bp]); else n_pass++;
    n_chk++; if (req_log[br] !== 32'h100) $display("FAIL drop_req_addr: got %0h want 100", req_log[br]); else n_pass++;
  endtask

  task automatic test_both_redirect();
    int bp = push_cnt;
    bit ok;
    lat = 1;
    rob_rst = 1'b1; rob_pc = 32'h200; bp_rst = 1'b1; bp_pc = 32'h300; full = 1'b0;
    cyc();
    rob_rst = 1'b0; bp_rst = 1'b0;
    n_chk++; if (mc_en !== 1'b0) $display("FAIL both_no_req: got %0h want 0", mc_en); else n_pass++;
    cyc();
    n_chk++; if (mc_en !== 1'b1 || mc_addr !== 32'h200) $display("FAIL both_req_addr: got en %0h addr %0h want 1 200", mc_en, mc_addr); else n_pass++;
    wait_push(bp + 1, 20, ok);
    full = 1'b1;
    n_chk++; if (!ok || push_pc_log[bp] !== 32'h200 || push_inst_log[bp] !== 32'hC0DE0200)
      $display("FAIL both_push: got ok %0d pc %0h inst %0h want 1 200 c0de0200", ok, push_pc_log[bp], push_inst_log[bp]); else n_pass++;
  endtask

  task automatic test_redirect_same_cycle();
    int bp;
    mem_auto = 1'b0; man_rdy = 1'b0;
    full = 1'b0;
    cyc();
    n_chk++; if (mc_en !== 1'b1 || mc_addr !== 32'h204) $display("FAIL same_req: got en %0h addr %0h want 1 204", mc_en, mc_addr); else n_pass++;
    bp = push_cnt;
    man_rdy = 1'b1; man_inst = 32'hDEADBEEF; rob_rst = 1'b1; rob_pc = 32'h400; full = 1'b1;
    cyc();
    n_chk++; if (push !== 1'b0 || push_cnt !== bp) $display("FAIL same_no_push: got push %0h cnt %0d want 0 0", push, push_cnt - bp); else n_pass++;
    n_chk++; if (mc_en !== 1'b0) $display("FAIL same_req_drop: got %0h want 0", mc_en); else n_pass++;
    man_rdy = 1'b0; rob_rst = 1'b0; full = 1'b0;
    cyc();
    n_chk++; if (mc_en !== 1'b1 || mc_addr !== 32'h400) $display("FAIL same_next_addr: got en %0h addr %0h want 1 400", mc_en, mc_addr); else n_pass++;
  endtask

  task automatic test_freeze();
    int bp = push_cnt;
    rdy_in = 1'b0; full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      man_rdy = (i == 1); man_inst = 32'h12345678;
      cyc();
      n_chk++; if (push !== 1'b0 || mc_en !== 1'b1 || mc_addr !== 32'h400)
        $display("FAIL freeze_hold%0d: got push %0h en %0h addr %0h want 0 1 400", i, push, mc_en, mc_addr); else n_pass++;
    end
    n_chk++; if (push_cnt !== bp) $display("FAIL freeze_no_push: got %0d pushes want 0", push_cnt - bp); else n_pass++;
    rdy_in = 1'b1; man_rdy = 1'b1;
    cyc();
    man_rdy = 1'b0;
    n_chk++; if (push !== 1'b1 || inst_out !== 32'h12345678 || pc_out !== 32'h400 || mc_en !== 1'b0)
      $display("FAIL freeze_resume: got push %0h inst %0h pc %0h en %0h want 1 12345678 400 0", push, inst_out, pc_out, mc_en); else n_pass++;
    cyc();
    n_chk++; if (push !== 1'b0) $display("FAIL freeze_pulse: got %0h want 0", push); else n_pass++;
  endtask

  task automatic test_async_reset();
    full = 1'b0;
    cyc();
    n_chk++; if (mc_en !== 1'b1 || mc_addr !== 32'h404) $display("FAIL arst_req: got en %0h addr %0h want 1 404", mc_en, mc_addr); else n_pass++;
    #2 rst_in = 1'b0;
    #1;
    n_chk++; if (mc_en !== 1'b0 || mc_addr !== 32'h0 || push !== 1'b0 || inst_out !== 32'h13 || pc_out !== 32'h0)
      $display("FAIL arst_outputs: got en %0h addr %0h push %0h inst %0h pc %0h want 0 0 0 13 0", mc_en, mc_addr, push, inst_out, pc_out); else n_pass++;
    cyc();
    full = 1'b1; rst_in = 1'b1;
    cyc();
    full = 1'b0;
    cyc();
    n_chk++; if (mc_en !== 1'b1 || mc_addr !== 32'h0) $display("FAIL arst_restart: got en %0h addr %0h want 1 0", mc_en, mc_addr); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_full();
    test_drop();
    test_both_redirect();
    test_redirect_same_cycle();
    test_freeze();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
